// File: rtl/ps2_direction_decoder.sv
// PS/2 set-2 scan-code parser: E0/F0 prefix tracking, arrow move vector,
// held-key mask, P pause toggle and sequence timeout.
module ps2_direction_decoder #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic [7:0]  received_data,
   input  logic        received_data_en,
   output logic [15:0] move,
   output logic        move_valid,
   output logic [3:0]  held,
   output logic        pause,
   output logic        seq_error
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] B_EXT = 8'hE0;
   localparam logic [7:0] B_BRK = 8'hF0;
   localparam logic [7:0] B_P   = 8'h4D;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    byte_q;
   logic          byte_en_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   move_q, move_d;
   logic          move_valid_q, move_valid_d;
   logic [3:0]    held_q, held_d;
   logic          pause_q, pause_d;
   logic          seq_error_q, seq_error_d;
   logic          p_held_q, p_held_d;

   logic          arrow_hit;
   logic [15:0]   arrow_dir;
   logic [3:0]    arrow_mask;

   // Input capture stage; the FSM works on the byte one cycle later.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         byte_q    <= 8'h00;
         byte_en_q <= 1'b0;
      end else begin
         byte_q    <= received_data;
         byte_en_q <= received_data_en;
      end
   end

   // held bit order is {up, down, left, right}
   always_comb begin
      arrow_hit  = 1'b0;
      arrow_dir  = 16'h0000;
      arrow_mask = 4'b0000;
      case (byte_q)
         8'h75: begin
            arrow_hit  = 1'b1;
            arrow_dir  = 16'h00FF;
            arrow_mask = 4'b1000;
         end
         8'h72: begin
            arrow_hit  = 1'b1;
            arrow_dir  = 16'h0001;
            arrow_mask = 4'b0100;
         end
         8'h6B: begin
            arrow_hit  = 1'b1;
            arrow_dir  = 16'hFF00;
            arrow_mask = 4'b0010;
         end
         8'h74: begin
            arrow_hit  = 1'b1;
            arrow_dir  = 16'h0100;
            arrow_mask = 4'b0001;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      move_d       = move_q;
      move_valid_d = 1'b0;
      held_d       = held_q;
      pause_d      = pause_q;
      seq_error_d  = 1'b0;
      p_held_d     = p_held_q;

      if (byte_en_q) begin
         // A byte always beats a timeout expiring in the same cycle.
         cnt_d = '0;
         if (byte_q == B_EXT) begin
            state_d = EXT;
         end else if (byte_q == B_BRK) begin
            unique case (state_q)
               IDLE:    state_d = BRK;
               EXT:     state_d = EXT_BRK;
               default: begin
                  state_d     = IDLE;
                  seq_error_d = 1'b1;
               end
            endcase
         end else begin
            state_d = IDLE;
            unique case (state_q)
               IDLE: begin
                  if (byte_q == B_P && !p_held_q) begin
                     pause_d  = ~pause_q;
                     p_held_d = 1'b1;
                  end
               end
               EXT: begin
                  if (arrow_hit) begin
                     held_d       = held_q | arrow_mask;
                     move_d       = arrow_dir;
                     move_valid_d = (arrow_dir != move_q);
                  end
               end
               BRK: begin
                  if (byte_q == B_P) begin
                     p_held_d = 1'b0;
                  end
               end
               EXT_BRK: begin
                  if (arrow_hit) begin
                     held_d = held_q & ~arrow_mask;
                  end
               end
            endcase
         end
      end else if (state_q != IDLE) begin
         if (cnt_q == LAST) begin
            state_d     = IDLE;
            cnt_d       = '0;
            seq_error_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         move_q       <= 16'h0000;
         move_valid_q <= 1'b0;
         held_q       <= 4'b0000;
         pause_q      <= 1'b0;
         seq_error_q  <= 1'b0;
         p_held_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         move_q       <= move_d;
         move_valid_q <= move_valid_d;
         held_q       <= held_d;
         pause_q      <= pause_d;
         seq_error_q  <= seq_error_d;
         p_held_q     <= p_held_d;
      end
   end

   assign move       = move_q;
   assign move_valid = move_valid_q;
   assign held       = held_q;
   assign pause      = pause_q;
   assign seq_error  = seq_error_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Self-checking bench for ps2_direction_decoder: scoreboard of expected
// move values versus observed move_valid pulses, plus direct output checks.
module tb_ps2_direction_decoder;

   localparam int T = 16;

   logic        clk;
   logic        resetn;
   logic [7:0]  data;
   logic        en;
   logic [15:0] move;
   logic        move_valid;
   logic [3:0]  held;
   logic        pause;
   logic        seq_error;

   int tests;
   int failed;
   int se_cnt;
   logic [15:0] exp_q[$];
   logic [15:0] obs_q[$];

   ps2_direction_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .CLOCK_50        (clk),
      .resetn          (resetn),
      .received_data   (data),
      .received_data_en(en),
      .move            (move),
      .move_valid      (move_valid),
      .held            (held),
      .pause           (pause),
      .seq_error       (seq_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the next falling edge and record DUT pulses there.
   task automatic tick();
      @(negedge clk);
      if (resetn && move_valid) obs_q.push_back(move);
      if (resetn && seq_error) se_cnt++;
   endtask

   task automatic send(input logic [7:0] b);
      data = b;
      en   = 1'b1;
      tick();
      en   = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      en     = 1'b0;
      data   = 8'h00;
      tick();
      tick();
      resetn = 1'b1;
      tick();
      tests++;
      if ({move, move_valid, held, pause, seq_error} !== 23'd0) begin
         failed++;
         $display("FAIL reset_state got move=%h mv=%b held=%b pause=%b err=%b exp all 0",
                  move, move_valid, held, pause, seq_error);
      end
   endtask

   task automatic test_up();
      logic [15:0] e, o;
      send(8'hE0);
      send(8'h75);
      exp_q.push_back(16'h00FF);
      tests++;
      if (obs_q.size() != 0 || move !== 16'h0000) begin
         failed++;
         $display("FAIL up_latency got pulses=%0d move=%h exp 0 and 0000",
                  obs_q.size(), move);
      end
      tick();
      tests++;
      if (move_valid !== 1'b1) begin
         failed++;
         $display("FAIL up_pulse_time got mv=%b exp 1", move_valid);
      end
      tick();
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if (obs_q.size() == 0) begin
            failed++;
            $display("FAIL up_sb got no pulse exp move=%h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               failed++;
               $display("FAIL up_sb got %h exp %h", o, e);
            end
         end
      end
      tests++;
      if (obs_q.size() != 0 || held !== 4'b1000) begin
         failed++;
         $display("FAIL up_held got held=%b extra=%0d exp 1000 and 0",
                  held, obs_q.size());
      end
   endtask

   task automatic test_left_repeat_break();
      logic [15:0] e, o;
      send(8'hE0);
      send(8'h6B);
      exp_q.push_back(16'hFF00);
      tick();
      send(8'hE0);
      send(8'h6B);
      tick();
      tests++;
      if (held !== 4'b1010) begin
         failed++;
         $display("FAIL left_held got %b exp 1010", held);
      end
      send(8'hE0);
      send(8'hF0);
      send(8'h6B);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      repeat (3) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if (obs_q.size() == 0) begin
            failed++;
            $display("FAIL left_sb got no pulse exp move=%h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               failed++;
               $display("FAIL left_sb got %h exp %h", o, e);
            end
         end
      end
      tests++;
      if (obs_q.size() != 0) begin
         failed++;
         $display("FAIL left_repeat_silent got %0d extra pulses exp 0", obs_q.size());
         obs_q.delete();
      end
      tests++;
      if (held !== 4'b0000 || move !== 16'hFF00) begin
         failed++;
         $display("FAIL left_break got held=%b move=%h exp 0000 ff00", held, move);
      end
   endtask

   task automatic test_keypad();
      send(8'h75);
      send(8'h6B);
      repeat (3) tick();
      tests++;
      if (move !== 16'hFF00 || held !== 4'b0000 || obs_q.size() != 0) begin
         failed++;
         $display("FAIL keypad got move=%h held=%b pulses=%0d exp ff00 0000 0",
                  move, held, obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_pause();
      send(8'h4D);
      tick();
      tests++;
      if (pause !== 1'b1) begin
         failed++;
         $display("FAIL pause_press got %b exp 1", pause);
      end
      send(8'h4D);
      tick();
      tests++;
      if (pause !== 1'b1) begin
         failed++;
         $display("FAIL pause_repeat got %b exp 1", pause);
      end
      send(8'hF0);
      send(8'h4D);
      tick();
      tests++;
      if (pause !== 1'b1) begin
         failed++;
         $display("FAIL pause_break got %b exp 1", pause);
      end
      send(8'h4D);
      tick();
      tests++;
      if (pause !== 1'b0) begin
         failed++;
         $display("FAIL pause_second got %b exp 0", pause);
      end
   endtask

   task automatic test_timeout();
      int first;
      int se0;
      first = 0;
      se0   = se_cnt;
      send(8'hE0);
      for (int i = 1; i <= 3 * T; i++) begin
         tick();
         if (seq_error === 1'b1 && first == 0) first = i;
      end
      tests++;
      if (first != T + 1) begin
         failed++;
         $display("FAIL timeout_time got cycle %0d exp %0d", first, T + 1);
      end
      tests++;
      if (se_cnt - se0 != 1) begin
         failed++;
         $display("FAIL timeout_count got %0d pulses exp 1", se_cnt - se0);
      end
      send(8'h74);
      repeat (3) tick();
      tests++;
      if (move !== 16'hFF00 || held !== 4'b0000 || obs_q.size() != 0) begin
         failed++;
         $display("FAIL timeout_idle got move=%h held=%b pulses=%0d exp ff00 0000 0",
                  move, held, obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_byte_wins();
      logic [15:0] e, o;
      int se0;
      se0 = se_cnt;
      send(8'hE0);
      repeat (T - 1) tick();
      send(8'h74);
      exp_q.push_back(16'h0100);
      repeat (4) tick();
      tests++;
      if (se_cnt != se0 || held !== 4'b0001) begin
         failed++;
         $display("FAIL byte_wins got err=%0d held=%b exp 0 0001", se_cnt - se0, held);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if (obs_q.size() == 0) begin
            failed++;
            $display("FAIL byte_wins_sb got no pulse exp move=%h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               failed++;
               $display("FAIL byte_wins_sb got %h exp %h", o, e);
            end
         end
      end
      send(8'hE0);
      send(8'hF0);
      send(8'h74);
      tick();
      tests++;
      if (held !== 4'b0000 || move !== 16'h0100) begin
         failed++;
         $display("FAIL right_break got held=%b move=%h exp 0000 0100", held, move);
      end
   endtask

   task automatic test_f0_f0();
      int se0;
      se0 = se_cnt;
      send(8'hF0);
      tick();
      send(8'hF0);
      tests++;
      if (seq_error !== 1'b0) begin
         failed++;
         $display("FAIL f0f0_early got %b exp 0", seq_error);
      end
      tick();
      tests++;
      if (seq_error !== 1'b1) begin
         failed++;
         $display("FAIL f0f0_pulse got %b exp 1", seq_error);
      end
      tick();
      tests++;
      if (seq_error !== 1'b0 || se_cnt - se0 != 1) begin
         failed++;
         $display("FAIL f0f0_width got err=%b pulses=%0d exp 0 1",
                  seq_error, se_cnt - se0);
      end
      send(8'h72);
      repeat (2) tick();
      tests++;
      if (move !== 16'h0100 || held !== 4'b0000) begin
         failed++;
         $display("FAIL f0f0_idle got move=%h held=%b exp 0100 0000", move, held);
      end
   endtask

   task automatic test_reset_mid();
      send(8'h4D);
      send(8'hE0);
      send(8'h75);
      tick();
      send(8'hE0);
      tick();
      obs_q.delete();
      resetn = 1'b0;
      #1;
      tests++;
      if ({move, move_valid, held, pause, seq_error} !== 23'd0) begin
         failed++;
         $display("FAIL reset_mid got move=%h mv=%b held=%b pause=%b err=%b exp all 0",
                  move, move_valid, held, pause, seq_error);
      end
      tick();
      resetn = 1'b1;
      tick();
      send(8'h72);
      repeat (3) tick();
      tests++;
      if (move !== 16'h0000 || held !== 4'b0000 || obs_q.size() != 0) begin
         failed++;
         $display("FAIL reset_tail got move=%h held=%b pulses=%0d exp 0000 0000 0",
                  move, held, obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] e, o;
      send(8'hE0);
      send(8'h72);
      exp_q.push_back(16'h0001);
      send(8'hE0);
      send(8'h74);
      exp_q.push_back(16'h0100);
      repeat (3) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if (obs_q.size() == 0) begin
            failed++;
            $display("FAIL b2b_sb got no pulse exp move=%h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               failed++;
               $display("FAIL b2b_sb got %h exp %h", o, e);
            end
         end
      end
      tests++;
      if (held !== 4'b0101 || move !== 16'h0100 || obs_q.size() != 0) begin
         failed++;
         $display("FAIL b2b_final got held=%b move=%h extra=%0d exp 0101 0100 0",
                  held, move, obs_q.size());
      end
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      se_cnt = 0;
      test_reset();
      test_up();
      test_left_repeat_break();
      test_keypad();
      test_pause();
      test_timeout();
      test_byte_wins();
      test_f0_f0();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
